inst_mem_loader: RTL
====================

Name: inst_mem_loader

Overview:
- Write-side counterpart of the instruction memory read port.
- Takes a byte stream (e.g. from the UART boot path), packs bytes little-endian into 32-bit instruction words, and writes them sequentially into instruction memory from a base address.
- Holds the core off (busy_o) while loading; reports completion and errors.

Parameters:
- BASE_ADDR, 32'h0000_0000, byte address of the first word written.
- MAX_WORDS, 4096, instruction memory capacity in words (equals InstMemNum).
- LEN_W, 16, width of the word-count input.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  reset, asynchronous, active-high (RstEnable = 1'b1).
- start_i  input  1  one-cycle pulse; starts a load; sampled only in IDLE.
- len_i  input  LEN_W  number of words to load; sampled with start_i.
- byte_valid_i  input  1  byte stream valid.
- byte_data_i  input  8  byte stream data.
- byte_ready_o  output  1  loader accepts a byte this cycle.
- we_o  output  1  instruction memory write enable (WriteEnable = 1).
- waddr_o  output  32  byte address (InstAddrBus), word aligned.
- wdata_o  output  32  instruction word (InstBus).
- busy_o  output  1  load in progress; the core must stall fetch.
- done_o  output  1  one-cycle pulse at end of load, including error ends.
- err_o  output  1  sticky error flag; cleared on the next accepted start_i.

Behaviour:
- Reset: state IDLE; byte_ready_o=0, we_o=0, waddr_o=0, wdata_o=ZeroWord, busy_o=0, done_o=0, err_o=0, byte counter=0, word index=0.
- States and transitions:
  - IDLE: on start_i, latch len_i and clear err_o. If len_i==0, go to DONE. If len_i>MAX_WORDS, set err_o and go to DONE with no writes. Otherwise go to RECV.
  - RECV: byte_ready_o=1. A byte is accepted when byte_valid_i && byte_ready_o.
    - Byte k (0..3) goes to bits [8k+7:8k] of the assembly register.
    - On the 4th accepted byte, go to WRITE in the next cycle.
  - WRITE: one cycle; byte_ready_o=0; we_o=1; waddr_o = BASE_ADDR + (index<<2); wdata_o = assembled word.
    - Then index increments.
    - If the new index == len, go to DONE; else return to RECV with byte counter 0.
  - DONE: done_o=1 for exactly one cycle, then IDLE.
- busy_o is 1 in RECV, WRITE and DONE.
- we_o is only ever high in WRITE and is registered. waddr_o and wdata_o hold their last values outside WRITE.
- Latency:
  - Minimum 5 cycles per word (4 accepts + 1 write).
  - The last write is followed by the DONE cycle; busy_o falls the cycle after done_o.
- Back-pressure: a gap in byte_valid_i stalls RECV indefinitely. There is no timeout.
- start_i during busy_o is ignored, and len_i is not re-sampled.
- Address arithmetic is 32-bit, wrap ignored. len<=MAX_WORDS ensures waddr_o <= BASE_ADDR + 4*(MAX_WORDS-1).
- Reset mid-load: immediate return to IDLE. The partial word is discarded and no further write is issued. Words already written are not rolled back.

Optional Feature:
- Macro LOADER_CHECKSUM_EN.
- When defined:
  - After the last WRITE, enter CHK instead of DONE and receive 4 more bytes (little-endian) as an expected checksum.
  - The checksum is the 32-bit wraparound sum of all written words.
  - On mismatch, err_o=1. Then go to DONE.
  - Not applied when len==0 or len>MAX_WORDS.
- When undefined: no CHK state and no extra bytes; err_o is set only on length overflow.

Decomposition:
- Shared defines header (existing): InstAddrBus, InstBus, ZeroWord, WriteEnable/WriteDisable, RstEnable, InstMemNum. Add loader state encodings LdrIdle/LdrRecv/LdrWrite/LdrChk/LdrDone there.
- One natural sub-module: byte_packer (4-byte little-endian assembler with count and full flag), instantiated once.

Test Plan:
- len=2, bytes 13 00 00 00 93 00 10 00 -> we_o pulses twice: addr 0x0 data 0x00000013, then addr 0x4 data 0x00100093; one done_o; err_o=0.
- len=0 -> done_o 1 cycle after start; no we_o; busy_o high for 1 cycle only.
- len=MAX_WORDS+1 -> err_o=1, done_o pulse, no we_o; next start with len=1 clears err_o.
- byte_valid_i toggled randomly with gaps and start_i pulsed mid-load -> same writes as the gap-free run; the second start has no effect.
- rst asserted after 2 bytes of word 1 -> outputs at reset values immediately; a later load with len=1 writes addr BASE_ADDR with correct data.
- LOADER_CHECKSUM_EN, len=2 with the words above and trailer 0x001000A6 -> err_o=0; trailer 0x001000A7 -> err_o=1; done_o pulses in both cases.

Source files
------------

// File: rtl/inst_mem_loader_pkg.sv
// ============================================================================
// Module      : inst_mem_loader_pkg
// Description : Shared bus widths, write/reset polarities, memory size and
//               loader state encodings for the instruction-memory loader.
//               Optional feature macro: LOADER_CHECKSUM_EN (see top).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package inst_mem_loader_pkg;

   // Instruction memory bus geometry
   localparam int InstAddrBus = 32;
   localparam int InstBus     = 32;
   localparam int InstMemNum  = 4096;

   localparam logic [InstBus-1:0] ZeroWord = 32'h0000_0000;

   // Control polarities
   localparam logic WriteEnable  = 1'b1;
   localparam logic WriteDisable = 1'b0;
   localparam logic RstEnable    = 1'b1;

   // Loader state encodings
   typedef enum logic [2:0] {
      LdrIdle  = 3'd0,
      LdrRecv  = 3'd1,
      LdrWrite = 3'd2,
      LdrChk   = 3'd3,
      LdrDone  = 3'd4
   } ldr_state_t;

   // Byte address of word 'index' counted from 'base'
   function automatic logic [InstAddrBus-1:0] word_addr(
      input logic [InstAddrBus-1:0] base,
      input logic [InstAddrBus-1:0] index
   );
      return base + (index << 2);
   endfunction

endpackage

`default_nettype wire

// File: rtl/inst_mem_loader_byte_packer.sv
// ============================================================================
// Module      : inst_mem_loader_byte_packer
// Description : Four-byte little-endian word assembler. Byte k of a word lands
//               in bits [8k+7:8k]. Exposes the word as it will look after the
//               current accept so the caller can capture a finished word in
//               the same cycle its last byte arrives.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module inst_mem_loader_byte_packer
   import inst_mem_loader_pkg::*;
(
   input  logic               clk,
   input  logic               rst,
   input  logic               clear,
   input  logic               accept,
   input  logic [7:0]         byte_in,
   output logic [InstBus-1:0] word_next,
   output logic               full,
   output logic               last
);

   logic [InstBus-1:0] word;
   logic [2:0]         count;

   assign full = (count == 3'd4);
   assign last = accept && (count == 3'd3);

   // Merge the incoming byte into its lane of the assembly word
   always_comb begin
      word_next = word;
      if (accept && !full) begin
         word_next[{count[1:0], 3'b000} +: 8] = byte_in;
      end
   end

   // Assembly register and byte counter
   always_ff @(posedge clk or posedge rst) begin
      if (rst == RstEnable) begin
         word  <= ZeroWord;
         count <= 3'd0;
      end else if (clear) begin
         word  <= ZeroWord;
         count <= 3'd0;
      end else if (accept && !full) begin
         word  <= word_next;
         count <= count + 3'd1;
      end
   end

endmodule

`default_nettype wire

// File: rtl/inst_mem_loader.sv
// ============================================================================
// Module      : inst_mem_loader
// Description : Packs a byte stream little-endian into 32-bit words and writes
//               them sequentially into instruction memory from BASE_ADDR.
//               Holds the core off via busy_o while loading and reports done
//               and a sticky error.
//               Optional macro LOADER_CHECKSUM_EN: after the last word, four
//               more bytes carry the expected 32-bit wraparound sum of all
//               written words; a mismatch sets err_o.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module inst_mem_loader
   import inst_mem_loader_pkg::*;
#(
   parameter logic [InstAddrBus-1:0] BASE_ADDR = 32'h0000_0000,
   parameter int                     MAX_WORDS = InstMemNum,
   parameter int                     LEN_W     = 16
)(
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   start_i,
   input  logic [LEN_W-1:0]       len_i,
   input  logic                   byte_valid_i,
   input  logic [7:0]             byte_data_i,
   output logic                   byte_ready_o,
   output logic                   we_o,
   output logic [InstAddrBus-1:0] waddr_o,
   output logic [InstBus-1:0]     wdata_o,
   output logic                   busy_o,
   output logic                   done_o,
   output logic                   err_o
);

   ldr_state_t         state;
   ldr_state_t         state_nxt;

   logic [LEN_W-1:0]   len_q;
   logic [LEN_W-1:0]   idx;
   logic [LEN_W-1:0]   idx_inc;

   logic               start_ok;
   logic               len_zero;
   logic               len_over;
   logic               accept;
   logic               pack_clear;
   logic               pack_full;
   logic               word_done;
   logic               chk_bad;
   logic [InstBus-1:0] pack_word_next;

   assign start_ok = (state == LdrIdle) && start_i;
   assign len_zero = (len_i == '0);
   assign len_over = (InstAddrBus'(len_i) > InstAddrBus'(MAX_WORDS));
   assign idx_inc  = idx + LEN_W'(1);

   // Bytes are taken only while collecting a word (or checksum) with room left
   assign byte_ready_o = ((state == LdrRecv) || (state == LdrChk)) && !pack_full;
   assign accept       = byte_valid_i && byte_ready_o;

   // Assembly restarts fresh at the beginning of every word and of the trailer
   assign pack_clear   = (state == LdrIdle) || (state == LdrWrite);

   inst_mem_loader_byte_packer u_packer (
      .clk       (clk),
      .rst       (rst),
      .clear     (pack_clear),
      .accept    (accept),
      .byte_in   (byte_data_i),
      .word_next (pack_word_next),
      .full      (pack_full),
      .last      (word_done)
   );

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst == RstEnable) begin
         state <= LdrIdle;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state and status decode
   always_comb begin
      state_nxt = state;
      busy_o    = 1'b1;
      done_o    = 1'b0;
      case (state)
         LdrIdle: begin
            busy_o = 1'b0;
            if (start_i) begin
               if (len_zero || len_over) begin
                  state_nxt = LdrDone;
               end else begin
                  state_nxt = LdrRecv;
               end
            end
         end
         LdrRecv: begin
            if (word_done) begin
               state_nxt = LdrWrite;
            end
         end
         LdrWrite: begin
            if (idx_inc == len_q) begin
`ifdef LOADER_CHECKSUM_EN
               state_nxt = LdrChk;
`else
               state_nxt = LdrDone;
`endif
            end else begin
               state_nxt = LdrRecv;
            end
         end
`ifdef LOADER_CHECKSUM_EN
         LdrChk: begin
            if (word_done) begin
               state_nxt = LdrDone;
            end
         end
`endif
         LdrDone: begin
            done_o    = 1'b1;
            state_nxt = LdrIdle;
         end
         default: begin
            busy_o    = 1'b0;
            state_nxt = LdrIdle;
         end
      endcase
   end

`ifdef LOADER_CHECKSUM_EN
   logic [InstBus-1:0] sum;

   // Running wraparound sum of every word handed to memory in this load
   always_ff @(posedge clk or posedge rst) begin
      if (rst == RstEnable) begin
         sum <= ZeroWord;
      end else if (start_ok) begin
         sum <= ZeroWord;
      end else if ((state == LdrRecv) && word_done) begin
         sum <= sum + pack_word_next;
      end
   end

   assign chk_bad = (state == LdrChk) && word_done && (pack_word_next != sum);
`else
   assign chk_bad = 1'b0;
`endif

   // Load bookkeeping and registered memory write port
   always_ff @(posedge clk or posedge rst) begin
      if (rst == RstEnable) begin
         len_q   <= '0;
         idx     <= '0;
         err_o   <= 1'b0;
         we_o    <= WriteDisable;
         waddr_o <= ZeroWord;
         wdata_o <= ZeroWord;
      end else begin
         we_o <= WriteDisable;
         if (start_ok) begin
            len_q <= len_i;
            idx   <= '0;
            err_o <= len_over;
         end else if (chk_bad) begin
            err_o <= 1'b1;
         end
         // The word completes on its 4th byte; the write happens in the
         // following (WRITE) cycle straight from these registers.
         if ((state == LdrRecv) && word_done) begin
            we_o    <= WriteEnable;
            waddr_o <= word_addr(BASE_ADDR, InstAddrBus'(idx));
            wdata_o <= pack_word_next;
         end
         if (state == LdrWrite) begin
            idx <= idx_inc;
         end
      end
   end

endmodule

`default_nettype wire
